// File: rtl/ttes_shift_out_if.sv
// Parallel-word handshake between the ttes counter stage and the 595 serialiser.
interface ttes_shift_out_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              busy;

  modport master (output in_data, in_valid, input in_ready, busy);
  modport slave  (input in_data, in_valid, output in_ready, busy);
endinterface

// File: rtl/ttes_shift_out.sv
// Serialises a handshaked parallel word onto 74HC595 SER/SRCLK/RCLK pins.
// Optional SHIFT_OUT_SKIP_DUP_EN: drop accepted words equal to the last frame sent.
module ttes_shift_out #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  ttes_shift_out_if.slave  up,
  output logic             ser_out,
  output logic             srclk,
  output logic             rclk
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   shreg, shreg_nx, shreg_shifted;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]          div_cnt, div_cnt_nx, div_step;
  logic                ser_nx;
  logic                phase_end;
  logic                accept;
  logic                dup;

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  assign up.in_ready = (state == IDLE);
  assign up.busy     = (state != IDLE);
  assign accept      = up.in_valid && up.in_ready;
  assign phase_end   = (div_cnt == 8'(CLK_DIV - 1));
  assign div_step    = phase_end ? '0 : div_cnt + 8'd1;
  assign shreg_shifted = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

`ifdef SHIFT_OUT_SKIP_DUP_EN
  logic [DATA_W-1:0] last_sent, last_sent_nx;
  logic [DATA_W-1:0] frame_word, frame_word_nx;
  assign dup = (up.in_data == last_sent);
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    div_cnt_nx = '0;
    ser_nx     = ser_out;
`ifdef SHIFT_OUT_SKIP_DUP_EN
    last_sent_nx  = last_sent;
    frame_word_nx = frame_word;
`endif
    case (state)
      IDLE: begin
        if (accept && !dup) begin
          shreg_nx   = up.in_data;
          bit_cnt_nx = '0;
          ser_nx     = head_bit(up.in_data);
          state_nx   = SETUP;
`ifdef SHIFT_OUT_SKIP_DUP_EN
          frame_word_nx = up.in_data;
`endif
        end
      end
      SETUP: begin
        div_cnt_nx = div_step;
        if (phase_end) state_nx = HIGH;
      end
      HIGH: begin
        div_cnt_nx = div_step;
        if (phase_end) begin
          shreg_nx   = shreg_shifted;
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            state_nx = LATCH;
          end else begin
            state_nx = SETUP;
            ser_nx   = head_bit(shreg_shifted);
          end
        end
      end
      LATCH: begin
        div_cnt_nx = div_step;
        if (phase_end) begin
          state_nx = IDLE;
`ifdef SHIFT_OUT_SKIP_DUP_EN
          last_sent_nx = frame_word;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // srclk/rclk come from flops, not a decode of the 2-bit state, so the
  // SETUP->HIGH transition cannot glitch a clock pin on the board.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ser_out <= 1'b0;
      srclk   <= 1'b0;
      rclk    <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      div_cnt <= div_cnt_nx;
      ser_out <= ser_nx;
      srclk   <= (state_nx == HIGH);
      rclk    <= (state_nx == LATCH);
    end
  end

`ifdef SHIFT_OUT_SKIP_DUP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_sent  <= '0;
      frame_word <= '0;
    end else begin
      last_sent  <= last_sent_nx;
      frame_word <= frame_word_nx;
    end
  end
`endif

endmodule

// File: tb/tb_ttes_shift_out.sv
// Bench for ttes_shift_out: three configurations driving a 74HC595 model and a scoreboard.
module tb_ttes_shift_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic [7:0]  val;
  } sb_t;

  typedef struct {
    int unsigned idx;
    logic [7:0]  din;
    logic [7:0]  lat;
    int unsigned len;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  sb_t         exp_q[$];

  logic [7:0] v_data[3];
  logic       v_valid[3];
  logic       ser[3], sck[3], rck[3], rdy[3], bsy[3];
  logic [3:0] cnt4;
  logic [7:0] bench_last[3];

  // 595 model state per DUT
  logic [7:0]  sr[3], lat[3];
  logic        sck_p[3], rck_p[3];
  int unsigned sr_edges[3], frame_edges[3], pulses[3], rhigh[3];

  ttes_shift_out_if #(.DATA_W(8)) if0 ();
  ttes_shift_out_if #(.DATA_W(8)) if1 ();
  ttes_shift_out_if #(.DATA_W(4)) if2 ();

  assign if0.in_data  = v_data[0];
  assign if0.in_valid = v_valid[0];
  assign if1.in_data  = v_data[1];
  assign if1.in_valid = v_valid[1];
  assign if2.in_data  = cnt4;
  assign if2.in_valid = v_valid[2];
  assign rdy[0] = if0.in_ready;
  assign rdy[1] = if1.in_ready;
  assign rdy[2] = if2.in_ready;
  assign bsy[0] = if0.busy;
  assign bsy[1] = if1.busy;
  assign bsy[2] = if2.busy;

  ttes_shift_out #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .up(if0), .ser_out(ser[0]), .srclk(sck[0]), .rclk(rck[0]));
  ttes_shift_out #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .up(if1), .ser_out(ser[1]), .srclk(sck[1]), .rclk(rck[1]));
  ttes_shift_out #(.DATA_W(4), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst(rst), .up(if2), .ser_out(ser[2]), .srclk(sck[2]), .rclk(rck[2]));

  // upstream free-running 4-bit count feeding dut2
  always @(posedge clk) cnt4 <= rst ? 4'h0 : cnt4 + 4'h1;

  function automatic int unsigned dw(input int unsigned i);
    return (i == 2) ? 4 : 8;
  endfunction

  function automatic int unsigned dv(input int unsigned i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit push_exp(input int unsigned i, input logic [7:0] d, input logic [7:0] e);
`ifdef SHIFT_OUT_SKIP_DUP_EN
    if (d == bench_last[i]) return 1'b0;
`endif
    bench_last[i] = d;
    exp_q.push_back('{i, e});
    return 1'b1;
  endfunction

  // 595 model, sampled on the falling clk edge away from DUT updates
  always @(negedge clk) begin
    sb_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        frame_edges[i] = 0;
      end else begin
        if (sck[i] && !sck_p[i]) begin
          sr[i] = {sr[i][6:0], ser[i]};
          frame_edges[i]++;
          sr_edges[i]++;
        end
        if (rck[i] && !rck_p[i]) begin
          lat[i] = sr[i];
          rhigh[i] = 1;
          pulses[i]++;
          check("srclk_edges_per_frame", frame_edges[i], dw(i));
          frame_edges[i] = 0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_frame: dut%0d latched %0h, expected no frame", i, lat[i]);
          end else begin
            e = exp_q.pop_front();
            check("sb_dut_index", i, e.idx);
            check("sb_latched", (i == 2) ? {4'h0, lat[i][3:0]} : lat[i], e.val);
          end
        end else if (rck[i]) begin
          rhigh[i]++;
        end
        if (!rck[i] && rck_p[i]) check("rclk_pulse_len", rhigh[i], dv(i));
      end
      sck_p[i] = sck[i];
      rck_p[i] = rck[i];
    end
  end

  task automatic wait_ready(input int unsigned i);
    for (int k = 0; k < 300 && !rdy[i]; k++) @(negedge clk);
    check("ready_timeout", rdy[i], 1'b1);
  endtask

  task automatic send(input int unsigned i, input logic [7:0] d, input logic [7:0] e,
                      input int unsigned len);
    bit fr;
    int unsigned k, e0;
    wait_ready(i);
    v_data[i]  = d;
    v_valid[i] = 1'b1;
    fr = push_exp(i, d, e);
    e0 = sr_edges[i];
    @(negedge clk);
    v_valid[i] = 1'b0;
    check("ready_after_accept", rdy[i], !fr);
    check("busy_after_accept", bsy[i], fr);
    if (fr) begin
      k = 1;
      while (!rdy[i] && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("frame_len", k, len);
    end else begin
      repeat (8) @(negedge clk);
      check("skip_no_srclk", sr_edges[i], e0);
      check("skip_ready_high", rdy[i], 1'b1);
    end
  endtask

  vec_t tbl[6];

  initial begin
    int unsigned k, e0, p0, exp_frames;
    for (int i = 0; i < 3; i++) begin
      v_data[i] = '0; v_valid[i] = 1'b0; bench_last[i] = '0;
      sr[i] = '0; lat[i] = '0; sck_p[i] = 1'b0; rck_p[i] = 1'b0;
      sr_edges[i] = 0; frame_edges[i] = 0; pulses[i] = 0; rhigh[i] = 0;
    end
    tbl[0] = '{0, 8'hA5, 8'hA5, 69};
    tbl[1] = '{0, 8'h5A, 8'h5A, 69};
    tbl[2] = '{0, 8'h00, 8'h00, 69};
    tbl[3] = '{1, 8'h01, 8'h80, 18};
    tbl[4] = '{1, 8'hB2, 8'h4D, 18};
    tbl[5] = '{1, 8'h0F, 8'hF0, 18};

    repeat (3) @(negedge clk);
    check("rst_in_ready", rdy[0], 1'b1);
    check("rst_busy", bsy[0], 1'b0);
    check("rst_ser_out", ser[0], 1'b0);
    check("rst_srclk", sck[0], 1'b0);
    check("rst_rclk", rck[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // single words, both bit orders and divider settings
    for (int n = 0; n < 6; n++) send(tbl[n].idx, tbl[n].din, tbl[n].lat, tbl[n].len);

    // back-to-back with in_valid held and in_data disturbed mid-frame
    wait_ready(0);
    v_data[0] = 8'h3C; v_valid[0] = 1'b1;
    void'(push_exp(0, 8'h3C, 8'h3C));
    @(negedge clk);
    check("b2b_first_accept", rdy[0], 1'b0);
    repeat (20) @(negedge clk);
    v_data[0] = 8'h99;
    repeat (20) @(negedge clk);
    v_data[0] = 8'hC3;
    k = 41;
    while (!rdy[0] && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("b2b_first_len", k, 69);
    void'(push_exp(0, 8'hC3, 8'hC3));
    @(negedge clk);
    v_valid[0] = 1'b0;
    check("b2b_second_accept_same_cycle", rdy[0], 1'b0);
    wait_ready(0);

    // reset during the 4th HIGH phase of 8'hFF
    v_data[0] = 8'hFF; v_valid[0] = 1'b1;
    e0 = sr_edges[0];
    void'(push_exp(0, 8'hFF, 8'hFF));
    @(negedge clk);
    v_valid[0] = 1'b0;
    for (int n = 0; n < 300 && sr_edges[0] < e0 + 4; n++) @(negedge clk);
    check("abort_reached_4th_high", sr_edges[0] - e0, 4);
    rst = 1'b1;
    @(negedge clk);
    check("abort_srclk", sck[0], 1'b0);
    check("abort_rclk", rck[0], 1'b0);
    check("abort_ser_out", ser[0], 1'b0);
    check("abort_in_ready", rdy[0], 1'b1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) bench_last[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_595_unchanged", lat[0], 8'hC3);
    send(0, 8'h0F, 8'h0F, 69);

    // DATA_W=4 fed by the free-running count, in_valid held high
    @(negedge clk);
    v_valid[2] = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (rdy[2]) void'(push_exp(2, {4'h0, cnt4}, {4'h0, cnt4}));
      @(negedge clk);
    end
    v_valid[2] = 1'b0;
    wait_ready(2);
    check("count_frames_seen", pulses[2] >= 3, 1'b1);

    // duplicate-word handling
    p0 = pulses[0];
    send(0, 8'h55, 8'h55, 69);
    send(0, 8'h55, 8'h55, 69);
    send(0, 8'hAA, 8'hAA, 69);
`ifdef SHIFT_OUT_SKIP_DUP_EN
    exp_frames = 2;
`else
    exp_frames = 3;
`endif
    check("dup_frame_count", pulses[0] - p0, exp_frames);
    check("final_595_value", lat[0], 8'hAA);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
